// File: rtl/dram_cache_pkg.sv
// dram_cache_pkg: shared widths and FSM encoding for the DRAM cache AXI master.
package dram_cache_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 512;
  localparam int ID_W_DEF = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_ADDR = 2'd1,
    WR_ADDR_DATA = 2'd2
  } state_t;
endpackage

// File: rtl/axi_resp_slice.sv
// axi_resp_slice: single-entry response register merging R and B; R wins a same-cycle tie.
module axi_resp_slice
  import dram_cache_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic [ID_W-1:0]   bid,
  input  logic              bvalid,
  output logic              bready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [ID_W-1:0]   resp_id,
  output logic [DATA_W-1:0] resp_data
);
  logic r_fire, b_fire;
  assign rready = !resp_valid || resp_ready;
  assign bready = rready && !rvalid;
  assign r_fire = rvalid && rready;
  assign b_fire = bvalid && bready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) resp_valid <= 1'b0;
    else resp_valid <= r_fire || b_fire || (resp_valid && !resp_ready);
  // B keeps the previous payload; only the id and type change.
  always_ff @(posedge clk) begin
    if (r_fire || b_fire) begin
      resp_write <= !r_fire;
      resp_id <= r_fire ? rid : bid;
    end
    if (r_fire) resp_data <= rdata;
  end
endmodule

// File: rtl/axi_proc_master.sv
// axi_proc_master: issues one single-beat AXI read or write per command and tracks in-flight count.
module axi_proc_master
  import dram_cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W = ID_W_DEF,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              resp_write_o,
  output logic [ID_W-1:0]   resp_id_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic [ID_W-1:0]   arid_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [ID_W-1:0]   awid_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [ID_W-1:0]   rid_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [ID_W-1:0]   bid_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  output logic [3:0]        outstanding_o,
  output logic              err_o
);
  localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);
  state_t state;
  logic [ID_W-1:0] id_cnt, cur_id;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic aw_done, w_done;
  logic cmd_fire, ar_fire, aw_fire, w_fire, wr_done, inc, dec;
  assign cmd_ready_o = state == IDLE && outstanding_o < MAX_OUT_L;
  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign arvalid_o = state == RD_ADDR;
  assign awvalid_o = state == WR_ADDR_DATA && !aw_done;
  assign wvalid_o = state == WR_ADDR_DATA && !w_done;
  assign ar_fire = arvalid_o && arready_i;
  assign aw_fire = awvalid_o && awready_i;
  assign w_fire = wvalid_o && wready_i;
  assign wr_done = state == WR_ADDR_DATA && (aw_done || aw_fire) && (w_done || w_fire);
  assign inc = ar_fire || wr_done;
  assign dec = (rvalid_i && rready_o) || (bvalid_i && bready_o);
  assign arid_o = cur_id;
  assign awid_o = cur_id;
  assign araddr_o = addr_q;
  assign awaddr_o = addr_q;
  assign wdata_o = data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      id_cnt <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      outstanding_o <= 4'd0;
      err_o <= 1'b0;
    end else begin
      state <= cmd_fire ? (cmd_write_i ? WR_ADDR_DATA : RD_ADDR) : inc ? IDLE : state;
      id_cnt <= cmd_fire ? id_cnt + ID_W'(1) : id_cnt;
      aw_done <= cmd_fire ? 1'b0 : aw_done || aw_fire;
      w_done <= cmd_fire ? 1'b0 : w_done || w_fire;
      // A stray response with nothing in flight flags an error and never wraps the count.
      outstanding_o <= (inc && !dec) ? outstanding_o + 4'd1 :
                       (dec && !inc && outstanding_o != 4'd0) ? outstanding_o - 4'd1 : outstanding_o;
      err_o <= err_o || (dec && outstanding_o == 4'd0);
    end
  always_ff @(posedge clk)
    if (cmd_fire) begin
      addr_q <= cmd_addr_i;
      data_q <= cmd_data_i;
      cur_id <= id_cnt;
    end
  axi_resp_slice #(.DATA_W(DATA_W), .ID_W(ID_W)) u_resp (
    .clk(clk),
    .rst_n(rst_n),
    .rid(rid_i),
    .rdata(rdata_i),
    .rvalid(rvalid_i),
    .rready(rready_o),
    .bid(bid_i),
    .bvalid(bvalid_i),
    .bready(bready_o),
    .resp_valid(resp_valid_o),
    .resp_ready(resp_ready_i),
    .resp_write(resp_write_o),
    .resp_id(resp_id_o),
    .resp_data(resp_data_o)
  );
endmodule

// File: tb/tb_axi_proc_master.sv
// tb_axi_proc_master: directed and randomized checks against a transaction-level reference model.
module tb_axi_proc_master;
  typedef struct {
    bit w;
    logic [15:0] id;
    logic [511:0] data;
    bit known;
  } resp_t;
  logic clk, rst_n;
  logic cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [63:0] cmd_addr_i;
  logic [511:0] cmd_data_i;
  logic resp_valid_o, resp_ready_i, resp_write_o;
  logic [15:0] resp_id_o;
  logic [511:0] resp_data_o;
  logic [15:0] arid_o, awid_o, rid_i, bid_i;
  logic [63:0] araddr_o, awaddr_o;
  logic arvalid_o, arready_i, awvalid_o, awready_i, wvalid_o, wready_i;
  logic [511:0] wdata_o, rdata_i;
  logic rvalid_i, rready_o, bvalid_i, bready_o;
  logic [3:0] outstanding_o;
  logic err_o;
  int checks = 0, errors = 0;
  int out;
  bit m_err, act, c_rd, c_aw, c_w, have_rd;
  logic [15:0] next_id, c_id;
  logic [63:0] c_addr;
  logic [511:0] c_data, last_rd;
  resp_t resp_q[$];
  bit f_cmd, f_ar, f_wr, f_r, f_b;
  logic [15:0] f_id;
  logic [15:0] rd_pend[$], wr_pend[$];

  axi_proc_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_write_o(resp_write_o),
    .resp_id_o(resp_id_o), .resp_data_o(resp_data_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .bid_i(bid_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_data_i = '0;
    resp_ready_i = 0; arready_i = 0; awready_i = 0; wready_i = 0;
    rid_i = '0; rdata_i = '0; rvalid_i = 0; bid_i = '0; bvalid_i = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    idle_inputs();
    out = 0; m_err = 0; next_id = 0; act = 0; have_rd = 0;
    resp_q.delete();
    {f_cmd, f_ar, f_wr, f_r, f_b} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // One clock of the reference: compare everything visible, then advance by the spec's rules.
  task automatic cycle();
    bit exp_rdy, exp_rr, exp_br, ar_f, aw_f, w_f, wr_d, r_f, b_f, inc, dec;
    resp_t rr;
    #1;
    exp_rdy = !act && out < 4;
    exp_rr = resp_q.size() == 0 || resp_ready_i;
    exp_br = exp_rr && !rvalid_i;
    chk("cmd_ready", cmd_ready_o, exp_rdy);
    chk("arvalid", arvalid_o, act && c_rd);
    chk("awvalid", awvalid_o, act && !c_rd && !c_aw);
    chk("wvalid", wvalid_o, act && !c_rd && !c_w);
    if (act && c_rd) begin
      chk("arid", arid_o, c_id);
      chk("araddr", araddr_o, c_addr);
    end
    if (act && !c_rd && !c_aw) begin
      chk("awid", awid_o, c_id);
      chk("awaddr", awaddr_o, c_addr);
    end
    if (act && !c_rd && !c_w) chk("wdata", wdata_o, c_data);
    chk("rready", rready_o, exp_rr);
    chk("bready", bready_o, exp_br);
    chk("outstanding", outstanding_o, 4'(out));
    chk("err", err_o, m_err);
    chk("resp_valid", resp_valid_o, resp_q.size() != 0);
    if (resp_q.size() != 0) begin
      chk("resp_write", resp_write_o, resp_q[0].w);
      chk("resp_id", resp_id_o, resp_q[0].id);
      if (resp_q[0].known) chk("resp_data", resp_data_o, resp_q[0].data);
    end
    ar_f = act && c_rd && arready_i;
    aw_f = act && !c_rd && !c_aw && awready_i;
    w_f = act && !c_rd && !c_w && wready_i;
    wr_d = act && !c_rd && (c_aw || aw_f) && (c_w || w_f);
    r_f = rvalid_i && exp_rr;
    b_f = bvalid_i && exp_br;
    inc = ar_f || wr_d;
    dec = r_f || b_f;
    if (dec && out == 0) m_err = 1;
    if (inc && !dec) out++;
    else if (dec && !inc && out > 0) out--;
    if (resp_q.size() != 0 && resp_ready_i) void'(resp_q.pop_front());
    if (r_f) begin
      rr.w = 0; rr.id = rid_i; rr.data = rdata_i; rr.known = 1;
      resp_q.push_back(rr);
      last_rd = rdata_i; have_rd = 1;
    end else if (b_f) begin
      rr.w = 1; rr.id = bid_i; rr.data = last_rd; rr.known = have_rd;
      resp_q.push_back(rr);
    end
    f_cmd = cmd_valid_i && exp_rdy; f_ar = ar_f; f_wr = wr_d; f_r = r_f; f_b = b_f; f_id = c_id;
    if (inc) act = 0;
    else if (act) begin
      c_aw = c_aw || aw_f;
      c_w = c_w || w_f;
    end
    if (f_cmd) begin
      act = 1; c_rd = !cmd_write_i; c_addr = cmd_addr_i; c_data = cmd_data_i;
      c_id = next_id; next_id = next_id + 16'd1; c_aw = 0; c_w = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    do_reset();
    // Read with immediate AR accept, then a single R beat.
    cmd_valid_i = 1; cmd_write_i = 0; cmd_addr_i = 64'h0000000700000040;
    cycle();
    cmd_valid_i = 0; arready_i = 1;
    chk("rd_arvalid_lat", arvalid_o, 1);
    chk("rd_arid0", arid_o, 0);
    cycle();
    arready_i = 0; rvalid_i = 1; rid_i = 16'd0; rdata_i = {16{32'haaaaaaaa}}; resp_ready_i = 1;
    cycle();
    rvalid_i = 0;
    chk("rd_resp_valid", resp_valid_o, 1);
    chk("rd_resp_write", resp_write_o, 0);
    chk("rd_resp_data", resp_data_o, {16{32'haaaaaaaa}});
    // Write with AW accepted in cycle 1 and W in cycle 3.
    cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = 64'h0000000f00000040; cmd_data_i = {16{32'hbbbbbbbb}};
    cycle();
    cmd_valid_i = 0; awready_i = 1;
    cycle();
    awready_i = 0;
    chk("wr_aw_dropped", awvalid_o, 0);
    chk("wr_w_held", wvalid_o, 1);
    cycle();
    wready_i = 1;
    chk("wr_w_held3", wvalid_o, 1);
    cycle();
    wready_i = 0;
    chk("wr_idle_ready", cmd_ready_o, 1);
    chk("wr_outstanding", outstanding_o, 1);
    bvalid_i = 1; bid_i = 16'd1;
    cycle();
    bvalid_i = 0;
    chk("wr_b_write", resp_write_o, 1);
    chk("wr_b_id", resp_id_o, 1);
    chk("wr_b_data_kept", resp_data_o, {16{32'haaaaaaaa}});
    // Fill to MAX_OUT with reads, then release one slot.
    for (int i = 0; i < 4; i++) begin
      cmd_valid_i = 1; cmd_write_i = 0; cmd_addr_i = {$urandom, $urandom}; arready_i = 1;
      cycle();
      cmd_valid_i = 0;
      cycle();
    end
    arready_i = 0;
    chk("full_outstanding", outstanding_o, 4);
    chk("full_cmd_ready", cmd_ready_o, 0);
    rvalid_i = 1; rid_i = 16'd2; rdata_i = rand512();
    cycle();
    rvalid_i = 0;
    chk("slot_cmd_ready", cmd_ready_o, 1);
    // R and B in the same cycle: R first, B held.
    rvalid_i = 1; rid_i = 16'd3; rdata_i = rand512(); bvalid_i = 1; bid_i = 16'd9;
    #1;
    chk("tie_bready", bready_o, 0);
    cycle();
    rvalid_i = 0;
    chk("tie_r_first", resp_write_o, 0);
    chk("tie_r_id", resp_id_o, 3);
    cycle();
    bvalid_i = 0;
    chk("tie_b_next", resp_write_o, 1);
    chk("tie_b_id", resp_id_o, 9);
    // Stray B with nothing in flight.
    do_reset();
    bvalid_i = 1; bid_i = 16'd5; resp_ready_i = 1;
    cycle();
    bvalid_i = 0;
    chk("stray_err", err_o, 1);
    chk("stray_out", outstanding_o, 0);
    repeat (3) cycle();
    chk("stray_err_sticky", err_o, 1);
    // Reset while AW is pending.
    do_reset();
    cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = {$urandom, $urandom}; cmd_data_i = rand512();
    cycle();
    cmd_valid_i = 0;
    cycle();
    cycle();
    chk("pre_rst_awvalid", awvalid_o, 1);
    do_reset();
    chk("post_rst_wvalid", wvalid_o, 0);
    cmd_valid_i = 1; cmd_write_i = 0; cmd_addr_i = {$urandom, $urandom};
    cycle();
    cmd_valid_i = 0;
    chk("post_rst_id0", arid_o, 0);
    // Randomized traffic against a well-behaved slave.
    do_reset();
    rd_pend.delete();
    wr_pend.delete();
    for (int n = 0; n < 600; n++) begin
      if (f_r) void'(rd_pend.pop_front());
      if (f_b) void'(wr_pend.pop_front());
      if (f_ar) rd_pend.push_back(f_id);
      if (f_wr) wr_pend.push_back(f_id);
      if (!cmd_valid_i || f_cmd) begin
        cmd_valid_i = $urandom_range(0, 1);
        cmd_write_i = $urandom_range(0, 1);
        cmd_addr_i = {$urandom, $urandom};
        cmd_data_i = rand512();
      end
      arready_i = $urandom_range(0, 1);
      awready_i = $urandom_range(0, 1);
      wready_i = $urandom_range(0, 1);
      if (!(rvalid_i && !f_r)) begin
        rvalid_i = rd_pend.size() != 0 && $urandom_range(0, 2) == 0;
        if (rvalid_i) begin rid_i = rd_pend[0]; rdata_i = rand512(); end
      end
      if (!(bvalid_i && !f_b)) begin
        bvalid_i = wr_pend.size() != 0 && $urandom_range(0, 2) == 0;
        if (bvalid_i) bid_i = wr_pend[0];
      end
      resp_ready_i = $urandom_range(0, 3) != 0;
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
